// File: rtl/ones_count_pkg.sv
// Shared types and 7-segment encoding for the ones-count display block.
// Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package ones_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  function automatic logic [6:0] seg7_hex(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ones_count_display_sync.sv
// Multi-flop synchroniser for a single asynchronous level input.
// Clears to 0 on reset so a held request is re-detected afterwards.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ones_count_display.sv
// Serial population count of data_in after a synchronised start request,
// shown on one active-low 7-segment digit.
module ones_count_display
  import ones_count_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = $clog2(WIDTH + 1),
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [CNT_W-1:0] num_ones,
  output logic             done,
  output logic [6:0]       hex
);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic             start_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_start_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (start),
    .q     (start_s)
  );

  // Shifting stops as soon as no set bits remain, so the run length
  // depends on the highest set bit rather than on WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      num_ones  <= '0;
      hex       <= SEG_0;
    end else begin
      hex <= seg7_hex(4'(num_ones));
      case (state)
        IDLE: begin
          shift_reg <= data_in;
          if (start_s) begin
            state    <= COUNT;
            num_ones <= '0;
          end
        end
        COUNT: begin
          if (shift_reg == '0) begin
            state <= DONE;
          end else begin
            num_ones  <= num_ones + CNT_W'(shift_reg[0]);
            shift_reg <= shift_reg >> 1;
          end
        end
        DONE: begin
          if (!start_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_ones_count_display.sv
// Directed bench for ones_count_display: vector table plus hand sequences
// for rearm, data change during count, and reset mid-count.
module tb_ones_count_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] num_ones;
  logic       done;
  logic [6:0] hex;

  int checks   = 0;
  int failures = 0;

  ones_count_display dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data_in  (data_in),
    .num_ones (num_ones),
    .done     (done),
    .hex      (hex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [3:0] ones;
    logic [6:0] seg;
    int         edges;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts posedges until done is seen high at a negedge; 0 means timeout.
  task automatic wait_done(input string name, output int edges);
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        edges = k;
        break;
      end
    end
    if (edges == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: done not seen within 20 cycles, got 0 expected 1", name);
    end
  endtask

  task automatic rearm_and_load(input logic [7:0] d);
    start = 1'b0;
    repeat (4) @(negedge clk);
    data_in = d;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   e;
    logic [3:0] prev;

    vecs[0] = '{8'h01, 4'd1, 7'b1111001, 5};
    vecs[1] = '{8'h00, 4'd0, 7'b1000000, 4};
    vecs[2] = '{8'hFF, 4'd8, 7'b0000000, 12};
    vecs[3] = '{8'hAA, 4'd4, 7'b0011001, 12};
    vecs[4] = '{8'h0F, 4'd4, 7'b0011001, 8};
    vecs[5] = '{8'h80, 4'd1, 7'b1111001, 12};
    vecs[6] = '{8'h7E, 4'd6, 7'b0000010, 11};
    vecs[7] = '{8'h15, 4'd3, 7'b0110000, 9};

    reset = 1'b0; start = 1'b0; data_in = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ones", 32'(num_ones), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hex",  32'(hex), 32'h40);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ones", 32'(num_ones), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_hex",  32'(hex), 32'h40);

    prev = 4'd0;
    for (int i = 0; i < 8; i++) begin
      rearm_and_load(vecs[i].data);
      check($sformatf("v%0d_rearm_done", i), 32'(done), 32'd0);
      check($sformatf("v%0d_hold_ones", i), 32'(num_ones), 32'(prev));
      start = 1'b1;
      wait_done($sformatf("v%0d", i), e);
      check($sformatf("v%0d_latency", i), 32'(e), 32'(vecs[i].edges));
      check($sformatf("v%0d_ones", i), 32'(num_ones), 32'(vecs[i].ones));
      check($sformatf("v%0d_hex", i), 32'(hex), 32'(vecs[i].seg));
      prev = vecs[i].ones;
    end

    // One-cycle low pulse on start rearms; new word 0x00.
    start = 1'b0; data_in = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pulse_done_low", 32'(done), 32'd0);
    wait_done("pulse", e);
    check("pulse_latency", 32'(e), 32'd2);
    check("pulse_ones", 32'(num_ones), 32'd0);
    check("pulse_hex", 32'(hex), 32'h40);

    // data_in change after leaving IDLE must not affect the count.
    rearm_and_load(8'hAA);
    start = 1'b1;
    repeat (4) @(negedge clk);
    data_in = 8'hFF;
    wait_done("dchg", e);
    check("dchg_latency", 32'(e), 32'd8);
    check("dchg_ones", 32'(num_ones), 32'd4);
    check("dchg_hex", 32'(hex), 32'b0011001);

    // Reset mid-count clears outputs immediately; restart counts correctly.
    rearm_and_load(8'hFF);
    start = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_ones_nonzero", 32'(num_ones != 4'd0), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ones", 32'(num_ones), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_hex", 32'(hex), 32'h40);
    @(negedge clk);
    reset = 1'b1;
    wait_done("restart", e);
    check("restart_latency", 32'(e), 32'd12);
    check("restart_ones", 32'(num_ones), 32'd8);
    check("restart_hex", 32'(hex), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
